// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared encodings for the multicycle RV32I controller.
package riscv_ctrl_pkg;
    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Unknown opcodes fall straight back to FETCH and act as a nop.
    function automatic state_t decode_next(input logic [6:0] op);
        return (op == OP_LW || op == OP_SW) ? S_MEMADR :
               (op == OP_R)   ? S_EXECUTER :
               (op == OP_I)   ? S_EXECUTEI :
               (op == OP_BEQ) ? S_BEQ :
               (op == OP_JAL) ? S_JAL : S_FETCH;
    endfunction
endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps aluop/funct3/funct7b5 onto the ALU operation code.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);
    always_comb begin
        alu_control = ALU_ADD;
        if (aluop == ALUOP_SUB)
            alu_control = ALU_SUB;
        else if (aluop == ALUOP_FUNC)
            case (funct3)
                // only R-type honours funct7b5; addi never subtracts
                3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                3'b010:  alu_control = ALU_SLT;
                3'b110:  alu_control = ALU_OR;
                3'b111:  alu_control = ALU_AND;
                default: alu_control = ALU_ADD;
            endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore sequencing FSM for the multicycle RV32I core.
// Define MEM_STALL_EN to add mem_ready, which stalls FETCH/MEMREAD/MEMWRITE.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
`ifdef MEM_STALL_EN
    input  logic       mem_ready,
`endif
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [2:0] alu_control,
    output logic       instr_done
);
    state_t state, state_nx;
    logic ready, pc_update, branch, ir_en, mem_en, reg_en, done;
    logic [1:0] aluop;

`ifdef MEM_STALL_EN
    assign ready = mem_ready;
`else
    assign ready = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nx;

    always_comb begin
        state_nx   = S_FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_en      = 1'b0;
        mem_en     = 1'b0;
        reg_en     = 1'b0;
        done       = 1'b0;
        adr_src    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_WD;
        aluop      = ALUOP_ADD;
        unique case (state)
            S_FETCH: begin
                state_nx   = ready ? S_DECODE : S_FETCH;
                ir_en      = ready;
                pc_update  = ready;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                state_nx  = decode_next(op);
                done      = (decode_next(op) == S_FETCH);
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                state_nx  = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                state_nx = ready ? S_MEMWB : S_MEMREAD;
                adr_src  = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_en     = 1'b1;
                done       = 1'b1;
            end
            S_MEMWRITE: begin
                state_nx = ready ? S_FETCH : S_MEMWRITE;
                adr_src  = 1'b1;
                mem_en   = ready;
                done     = ready;
            end
            S_EXECUTER: begin
                state_nx  = S_ALUWB;
                alu_src_a = SRCA_RD1;
                aluop     = ALUOP_FUNC;
            end
            S_EXECUTEI: begin
                state_nx  = S_ALUWB;
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                aluop     = ALUOP_FUNC;
            end
            S_ALUWB: begin
                reg_en = 1'b1;
                done   = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = SRCA_RD1;
                aluop     = ALUOP_SUB;
                branch    = 1'b1;
                done      = 1'b1;
            end
            S_JAL: begin
                state_nx  = S_ALUWB;
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: state_nx = S_FETCH;
        endcase
    end

    // Reset holds state at FETCH, so only the enables need explicit gating.
    assign pc_write   = rst_n & (pc_update | (branch & zero));
    assign ir_write   = rst_n & ir_en;
    assign mem_write  = rst_n & mem_en;
    assign reg_write  = rst_n & reg_en;
    assign instr_done = rst_n & done;

    assign imm_src = (op == OP_SW)  ? IMM_S :
                     (op == OP_BEQ) ? IMM_B :
                     (op == OP_JAL) ? IMM_J : IMM_I;

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random and directed instruction streams against a phase-table model.
module tb_multicycle_controller;
    localparam int PF = 0, PD = 1, PMA = 2, PMR = 3, PMWB = 4, PMW = 5;
    localparam int PXR = 6, PXI = 7, PWB = 8, PBQ = 9, PJ = 10;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111, NOP = 7'b0001111;

    typedef int iq_t[$];

    logic clk = 1'b0, rst_n = 1'b0, funct7b5 = 1'b0, zero = 1'b0, rdy = 1'b1;
    logic [6:0] op = LW;
    logic [2:0] funct3 = 3'b000;
    logic pc_write, adr_src, mem_write, ir_write, reg_write, instr_done;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [16:0] outs;
    int checks = 0, failures = 0;
`ifdef MEM_STALL_EN
    logic mem_ready = 1'b1;
`endif

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
`ifdef MEM_STALL_EN
        .mem_ready(mem_ready),
`endif
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .reg_write(reg_write), .alu_control(alu_control), .instr_done(instr_done)
    );

    assign outs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                   imm_src, reg_write, alu_control, instr_done};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h op=%b f3=%b f7=%b t=%0t", tag, got, exp, op, funct3, funct7b5, $time);
        end
    endtask

    function automatic bit known(input logic [6:0] o);
        return o inside {LW, SW, RT, IT, BQ, JL};
    endfunction

    function automatic logic [1:0] imm_ref(input logic [6:0] o);
        return o == SW ? 2'b01 : o == BQ ? 2'b10 : o == JL ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [16:0] reset_vec(input logic [6:0] o);
        return {4'b0000, 2'b10, 2'b00, 2'b10, imm_ref(o), 1'b0, 3'b000, 1'b0};
    endfunction

    // Walk of phases each instruction class is documented to take.
    function automatic iq_t phases(input logic [6:0] o);
        iq_t q;
        q.push_back(PF);
        q.push_back(PD);
        case (o)
            LW: begin q.push_back(PMA); q.push_back(PMR); q.push_back(PMWB); end
            SW: begin q.push_back(PMA); q.push_back(PMW); end
            RT: begin q.push_back(PXR); q.push_back(PWB); end
            IT: begin q.push_back(PXI); q.push_back(PWB); end
            BQ: q.push_back(PBQ);
            JL: begin q.push_back(PJ); q.push_back(PWB); end
            default: ;
        endcase
        return q;
    endfunction

    function automatic logic [16:0] model(input int ph, input logic z, input logic r,
                                          input logic [6:0] o, input logic [2:0] f3, input logic f7);
        logic pcw = 1'b0, adr = 1'b0, mw = 1'b0, irw = 1'b0, rw = 1'b0, dn = 1'b0;
        logic [1:0] res = 2'b00, sa = 2'b00, sb = 2'b00;
        logic [2:0] alu = 3'b000;
        case (ph)
            PF:   begin irw = r; pcw = r; sb = 2'b10; res = 2'b10; end
            PD:   begin sa = 2'b01; sb = 2'b01; dn = !known(o); end
            PMA:  begin sa = 2'b10; sb = 2'b01; end
            PMR:  adr = 1'b1;
            PMWB: begin res = 2'b01; rw = 1'b1; dn = 1'b1; end
            PMW:  begin adr = 1'b1; mw = r; dn = r; end
            PXR:  begin sa = 2'b10; alu = alu_ref(o, f3, f7); end
            PXI:  begin sa = 2'b10; sb = 2'b01; alu = alu_ref(o, f3, f7); end
            PWB:  begin rw = 1'b1; dn = 1'b1; end
            PBQ:  begin sa = 2'b10; alu = 3'b001; pcw = z; dn = 1'b1; end
            PJ:   begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            default: ;
        endcase
        return {pcw, adr, mw, irw, res, sa, sb, imm_ref(o), rw, alu, dn};
    endfunction

    // Entered just after a rising edge with the DUT in FETCH; zmode 2 randomises zero.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input int zmode);
        iq_t seq = phases(o);
        int i = 0, cyc = 0, dones = 0;
        op = o; funct3 = f3; funct7b5 = f7;
        while (i < seq.size() && cyc < 64) begin
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
`ifdef MEM_STALL_EN
            mem_ready = ($urandom_range(0, 3) != 0);
            rdy = mem_ready;
`endif
            #1;
            check("cycle", 32'(outs), 32'(model(seq[i], zero, rdy, o, f3, f7)));
            dones += int'(instr_done);
            if (!((seq[i] == PF || seq[i] == PMR || seq[i] == PMW) && !rdy)) i++;
            cyc++;
            @(posedge clk);
            #1;
        end
        check("budget", 32'(i), 32'(seq.size()));
        check("done_cnt", 32'(dones), 32'd1);
    endtask

    initial begin
        #3;
        check("rst_outs", 32'(outs), 32'(reset_vec(op)));
        @(posedge clk);
        #1;
        check("rst_hold", 32'(outs), 32'(reset_vec(op)));
        rst_n = 1'b1;
        run_instr(LW, 3'b010, 1'b0, 2);
        run_instr(RT, 3'b000, 1'b1, 2);
        run_instr(RT, 3'b000, 1'b0, 2);
        run_instr(IT, 3'b000, 1'b1, 2);
        run_instr(BQ, 3'b000, 1'b0, 1);
        run_instr(BQ, 3'b000, 1'b0, 0);
        run_instr(RT, 3'b010, 1'b0, 2);
        run_instr(RT, 3'b110, 1'b0, 2);
        run_instr(RT, 3'b111, 1'b1, 2);
        run_instr(JL, 3'b000, 1'b0, 2);
        run_instr(SW, 3'b010, 1'b0, 2);
        run_instr(NOP, 3'b000, 1'b0, 2);
        // Reset while MEMWRITE is driving mem_write.
        op = SW; funct3 = 3'b010; funct7b5 = 1'b0;
`ifdef MEM_STALL_EN
        mem_ready = 1'b1; rdy = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("mw_before_rst", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mw_in_rst", 32'(outs), 32'(reset_vec(op)));
        #2;
        rst_n = 1'b1;
        #1;
        check("post_rst_ir", 32'({ir_write, pc_write}), 32'b11);
        run_instr(SW, 3'b010, 1'b0, 2);
`ifdef MEM_STALL_EN
        op = NOP;
        mem_ready = 1'b0;
        repeat (3) begin
            #1;
            check("stall_fetch", 32'({ir_write, pc_write}), 32'b00);
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        #1;
        check("stall_accept", 32'({ir_write, pc_write}), 32'b11);
        @(posedge clk);
        #1;
        check("stall_decode", 32'(alu_src_a), 32'b01);
        @(posedge clk);
        #1;
`endif
        for (int n = 0; n < 300; n++) begin
            logic [6:0] o;
            logic [2:0] f3;
            case ($urandom_range(0, 6))
                0: o = LW;
                1: o = SW;
                2: o = RT;
                3: o = IT;
                4: o = BQ;
                5: o = JL;
                default: begin
                    o = 7'($urandom);
                    if (known(o)) o = NOP;
                end
            endcase
            f3 = ($urandom_range(0, 1) == 0) ? 3'($urandom) : 3'b000;
            run_instr(o, f3, 1'($urandom_range(0, 1)), 2);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing control unit for the multicycle variant of the RV32I core.
- Decodes op, funct3 and funct7b5, then steps a Moore FSM through fetch, decode, execute, memory and writeback.
- Drives the ALU's ALUControl/SrcA/SrcB select interface and consumes its Zero flag.
- Also drives the PC, instruction-register, memory and register-file enables of the shared-memory datapath.

Parameters:
- STATE_W, 4, width of the state register (11 states used).

Ports:
- clk  in  1  system clock. One clock.
- rst_n  in  1  reset, asynchronous, active-low.
- op  in  7  instruction opcode (Instr[6:0]).
- funct3  in  3  Instr[14:12].
- funct7b5  in  1  Instr[30].
- zero  in  1  ALU Zero flag.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0=PC, 1=Result.
- mem_write  out  1  memory write enable.
- ir_write  out  1  instruction/OldPC register enable.
- result_src  out  2  Result select: 00=ALUOut, 01=Data, 10=ALUResult.
- alu_src_a  out  2  SrcA select: 00=PC, 01=OldPC, 10=RD1.
- alu_src_b  out  2  SrcB select: 00=WriteData, 01=ImmExt, 10=constant 4.
- imm_src  out  2  immediate format: 00=I, 01=S, 10=B, 11=J.
- reg_write  out  1  register-file write enable.
- alu_control  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- State register is updated on rising clk. rst_n low asynchronously forces FETCH.
- While rst_n is low, pc_write, ir_write, mem_write, reg_write and instr_done are forced to 0. All other outputs take their FETCH values.
- Transitions:
  - FETCH -> DECODE.
  - DECODE:
    - op 0000011 or 0100011 -> MEMADR.
    - 0110011 -> EXECUTER.
    - 0010011 -> EXECUTEI.
    - 1100011 -> BEQ.
    - 1101111 -> JAL.
    - any other op -> FETCH (treated as a nop; instr_done pulses).
  - MEMADR: -> MEMREAD if op=0000011, else -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER and EXECUTEI -> ALUWB.
  - JAL -> ALUWB.
  - ALUWB -> FETCH.
  - BEQ -> FETCH.
- Per-state outputs. Unlisted outputs are 0. aluop is internal, 2 bits.
  - FETCH: ir_write=1, alu_src_b=10, result_src=10, pc_update=1.
  - DECODE: alu_src_a=01, alu_src_b=01 (branch/jump target computed).
  - MEMADR: alu_src_a=10, alu_src_b=01.
  - MEMREAD: adr_src=1.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, mem_write=1.
  - EXECUTER: alu_src_a=10, aluop=10.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, aluop=10.
  - ALUWB: reg_write=1.
  - BEQ: alu_src_a=10, aluop=01, branch=1.
  - JAL: alu_src_a=01, alu_src_b=10, pc_update=1.
- pc_write = pc_update OR (branch AND zero). This is combinational; zero is sampled in the BEQ cycle.
- imm_src is combinational from op alone: 0100011->01, 1100011->10, 1101111->11, else 00.
- alu_control:
  - aluop 00 -> 000; aluop 01 -> 001.
  - aluop 10 by funct3:
    - 000 -> 001 if (op[5] AND funct7b5), else 000. addi never subtracts.
    - 010 -> 101.
    - 110 -> 011.
    - 111 -> 010.
    - other funct3 -> 000.
- instr_done = 1 in MEMWB, MEMWRITE, ALUWB and BEQ, and in DECODE when the opcode is unknown.
- Latency in cycles: lw 5, sw 4, R/I 4, jal 4, beq 3, unknown 2.
- Reset mid-instruction: no further enables are issued. The next instruction begins with FETCH on the first clk edge after rst_n rises.

Optional Feature:
- Macro MEM_STALL_EN.
- When defined:
  - Adds input mem_ready (1 bit).
  - FETCH, MEMREAD and MEMWRITE hold their state while mem_ready=0.
  - ir_write, pc_update and mem_write are gated by mem_ready, so each asserts only in the accepting cycle.
  - The instr_done of MEMWRITE is gated the same way.
- When undefined: no port; behaves as if mem_ready=1.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state encoding constants.
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL).
  - ALUControl constants matching the ALU encoding.
  - aluop, result_src, src_a and src_b select constants.
- One combinational sub-module, alu_decoder: inputs aluop, funct3, op[5], funct7b5; output alu_control.

Test Plan:
- lw (op=0000011), reset released: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 and result_src=01 in the 5th cycle; instr_done pulses once.
- R-type sub (op=0110011, funct3=000, funct7b5=1): alu_control=001 in EXECUTER. With funct7b5=0, alu_control=000. addi with funct7b5=1 gives 000.
- beq with zero=1 in the BEQ cycle: pc_write=1, alu_control=001. With zero=0: pc_write=0. Both return to FETCH after 3 cycles.
- slt/or/and (funct3 010/110/111): alu_control 101/011/010 respectively.
- rst_n dropped during MEMWRITE: mem_write goes to 0 immediately. After release, state is FETCH with ir_write=1 and pc_write=1.
- MEM_STALL_EN with mem_ready=0 for 3 cycles in FETCH: ir_write and pc_write stay 0 and the state holds. They assert in the first cycle mem_ready=1, followed by DECODE.
